// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider.
// State encodings, widths and the latched sign bundle.
package div_iter_pkg;

    localparam int WORD  = 32;
    localparam int DWORD = 2 * WORD;

    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_CALC = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;

    typedef struct packed {
        logic qneg;
        logic rneg;
    } div_sign_t;

endpackage

// File: rtl/div_iter_sign_fix.sv
// Conditional two's-complement negate.
// Used for operand magnitudes and final result signs.
module div_sign_fix
    import div_iter_pkg::*;
#(
    parameter int WIDTH = WORD
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] fixed
);

    assign fixed = neg ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/div_iter.sv
// Radix-2 restoring divider for DIV/DIVU.
// Result is {remainder, quotient}, pulsed with div_ready.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH = WORD
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               div_start,
    input  logic               div_signed,
    input  logic [WIDTH-1:0]   div_opr1,
    input  logic [WIDTH-1:0]   div_opr2,
    input  logic               div_cancel,
    output logic               div_ready,
    output logic [2*WIDTH-1:0] div_res
);

    localparam int CW = $clog2(WIDTH);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    div_sign_t        sgn;

    logic [WIDTH-1:0] abs1;
    logic [WIDTH-1:0] abs2;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic             trial_unused;

    div_sign_fix #(.WIDTH(WIDTH)) u_abs1 (
        .neg   (div_signed & div_opr1[WIDTH-1]),
        .value (div_opr1),
        .fixed (abs1)
    );

    div_sign_fix #(.WIDTH(WIDTH)) u_abs2 (
        .neg   (div_signed & div_opr2[WIDTH-1]),
        .value (div_opr2),
        .fixed (abs2)
    );

    // Signs are applied to the final-step values so div_res is ready on DONE entry
    div_sign_fix #(.WIDTH(WIDTH)) u_quo_fix (
        .neg   (sgn.qneg),
        .value (quo_nxt),
        .fixed (quo_fix)
    );

    div_sign_fix #(.WIDTH(WIDTH)) u_rem_fix (
        .neg   (sgn.rneg),
        .value (rem_nxt),
        .fixed (rem_fix)
    );

    // Borrow is kept separately: the shifted partial remainder can exceed WIDTH bits
    always_comb begin
        {borrow, trial} = {2'b00, rem, quo[WIDTH-1]} - {2'b00, dvs};
        trial_unused    = trial[WIDTH];
        rem_nxt         = borrow ? {rem[WIDTH-2:0], quo[WIDTH-1]}
                                 : trial[WIDTH-1:0];
        quo_nxt         = {quo[WIDTH-2:0], ~borrow};
    end

    assign div_ready = (state == DIV_DONE) & ~div_cancel;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= DIV_IDLE;
            cnt     <= '0;
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            sgn     <= '0;
            div_res <= '0;
        end else if (div_cancel) begin
            state <= DIV_IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                DIV_IDLE: begin
                    if (div_start) begin
                        sgn.qneg <= div_signed &
                                    (div_opr1[WIDTH-1] ^ div_opr2[WIDTH-1]);
                        sgn.rneg <= div_signed & div_opr1[WIDTH-1];
                        quo      <= abs1;
                        dvs      <= abs2;
                        rem      <= '0;
                        cnt      <= '0;
                        if (div_opr2 == '0) begin
                            state   <= DIV_DONE;
                            div_res <= {div_opr1, {WIDTH{1'b1}}};
                        end else begin
                            state <= DIV_CALC;
                        end
                    end
                end
                DIV_CALC: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state   <= DIV_DONE;
                        div_res <= {rem_fix, quo_fix};
                    end
                end
                DIV_DONE: state <= DIV_IDLE;
                default:  state <= DIV_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter.
// Directed and random ops against an arithmetic reference.
module tb_div_iter;

    logic        clk;
    logic        resetn;
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_opr1;
    logic [31:0] div_opr2;
    logic        div_cancel;
    logic        div_ready;
    logic [63:0] div_res;

    int vectors;
    int miscompares;

    div_iter dut (
        .clk        (clk),
        .resetn     (resetn),
        .div_start  (div_start),
        .div_signed (div_signed),
        .div_opr1   (div_opr1),
        .div_opr2   (div_opr2),
        .div_cancel (div_cancel),
        .div_ready  (div_ready),
        .div_res    (div_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic s,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0)
            return {a, 32'hFFFF_FFFF};
        if (!s)
            return {a % b, a / b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; operands are scrambled while the op is in flight
    task automatic run_op(input string tag,
                          input logic s,
                          input logic [31:0] a,
                          input logic [31:0] b);
        logic [63:0] exp;
        logic [63:0] got;
        int          lat;
        int          want;
        exp  = model(s, a, b);
        want = (b == 32'd0) ? 1 : 33;
        lat  = 0;
        got  = '0;
        div_start  = 1'b1;
        div_signed = s;
        div_opr1   = a;
        div_opr2   = b;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (div_ready) begin
                lat = c;
                got = div_res;
                break;
            end
            div_opr1   = $urandom;
            div_opr2   = $urandom;
            div_signed = 1'($urandom);
        end
        div_start = 1'b0;
        chk({tag, "_lat"}, 64'(lat), 64'(want));
        chk({tag, "_res"}, got, exp);
        @(negedge clk);
        chk({tag, "_pulse"}, 64'(div_ready), 64'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        logic        seen;
        vectors     = 0;
        miscompares = 0;
        resetn      = 1'b0;
        div_start   = 1'b0;
        div_signed  = 1'b0;
        div_opr1    = '0;
        div_opr2    = '0;
        div_cancel  = 1'b0;

        #12;
        chk("rst_ready", 64'(div_ready), 64'd0);
        chk("rst_res", div_res, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        chk("plan_divu_100_7", model(1'b0, 32'd100, 32'd7),
            {32'd2, 32'd14});
        run_op("divu_100_7", 1'b0, 32'd100, 32'd7);
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        run_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
        run_op("divu_5_0", 1'b0, 32'd5, 32'd0);
        run_op("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0);
        run_op("div_5_min", 1'b1, 32'd5, 32'h8000_0000);
        run_op("divu_max_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // cancel in cycle 10, restart in cycle 12
        div_start  = 1'b1;
        div_signed = 1'b0;
        div_opr1   = 32'd1000;
        div_opr2   = 32'd3;
        seen       = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            seen |= div_ready;
        end
        div_cancel = 1'b1;
        div_start  = 1'b0;
        #1;
        seen |= div_ready;
        @(negedge clk);
        div_cancel = 1'b0;
        seen |= div_ready;
        @(negedge clk);
        seen |= div_ready;
        chk("cancel_no_ready", 64'(seen), 64'd0);
        run_op("divu_9_4", 1'b0, 32'd9, 32'd4);

        // cancel during DONE kills the pulse
        div_start  = 1'b1;
        div_signed = 1'b0;
        div_opr1   = 32'd7;
        div_opr2   = 32'd0;
        @(negedge clk);
        div_cancel = 1'b1;
        div_start  = 1'b0;
        #1;
        chk("cancel_done", 64'(div_ready), 64'd0);
        @(negedge clk);
        div_cancel = 1'b0;
        chk("cancel_done_next", 64'(div_ready), 64'd0);
        @(negedge clk);

        // asynchronous reset mid-CALC
        div_start  = 1'b1;
        div_signed = 1'b0;
        div_opr1   = 32'd12345;
        div_opr2   = 32'd17;
        repeat (8) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_ready", 64'(div_ready), 64'd0);
        chk("arst_res", div_res, 64'd0);
        div_start = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("plan_div_20_m3", model(1'b1, 32'd20, 32'hFFFF_FFFD),
            {32'd2, 32'hFFFF_FFFA});
        run_op("div_20_m3", 1'b1, 32'd20, 32'hFFFF_FFFD);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom);
            unique case (i % 4)
                0: rb = rb >> $urandom_range(31, 24);
                1: rb = (i % 8 == 1) ? 32'd0 : rb;
                2: ra = ra >> $urandom_range(20, 0);
                default: ;
            endcase
            run_op("rand", rs, ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
